// File: rtl/data_memory.sv
// Byte-addressed data memory with a fixed-latency access FSM.
// BUSYWAIT stalls the CPU from the request cycle until the access completes.
module data_memory #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned LATENCY    = 5
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  READ,
    input  logic                  WRITE,
    input  logic [ADDR_WIDTH-1:0] ADDRESS,
    input  logic [DATA_WIDTH-1:0] WRITEDATA,
    output logic [DATA_WIDTH-1:0] READDATA,
    output logic                  BUSYWAIT
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    wr_op_q, wr_op_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic                    req_c;
    logic                    fire_c;
    logic                    mem_we_c;

    // Next-state, latched request and stall output
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        wr_op_d  = wr_op_q;
        addr_d   = addr_q;
        data_d   = data_q;
        rdata_d  = rdata_q;
        BUSYWAIT = 1'b0;
        req_c    = READ | WRITE;
        fire_c   = (state_q == ACCESS) && (cnt_q == '0);

        case (state_q)
            IDLE: begin
                BUSYWAIT = req_c;
                if (req_c) begin
                    state_d = ACCESS;
                    cnt_d   = CNT_W'(LATENCY - 1);
                    // Simultaneous READ and WRITE degrades to a read
                    wr_op_d = WRITE & ~READ;
                    addr_d  = ADDRESS;
                    data_d  = WRITEDATA;
                end
            end
            ACCESS: begin
                BUSYWAIT = 1'b1;
                if (cnt_q != '0) begin
                    cnt_d = CNT_W'(cnt_q - 1'b1);
                end else begin
                    state_d = DONE;
                    if (!wr_op_q) begin
                        rdata_d = mem[addr_q];
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (RESET) begin
            BUSYWAIT = 1'b0;
        end
        mem_we_c = fire_c & wr_op_q & ~RESET;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wr_op_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_op_q <= wr_op_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            rdata_q <= rdata_d;
        end
    end

    // Storage array survives reset
    always_ff @(posedge CLK) begin
        if (mem_we_c) begin
            mem[addr_q] <= data_q;
        end
    end

    assign READDATA = rdata_q;

endmodule

// File: tb/tb_data_memory.sv
// Scoreboard bench for data_memory: a LATENCY=5 instance and a LATENCY=1 instance.
module tb_data_memory;

    logic       clk = 1'b0;
    logic       rst0, rd0, wr0, busy0;
    logic [7:0] a0, d0, rdata0;
    logic       rst1, rd1, wr1, busy1;
    logic [7:0] a1, d1, rdata1;

    int unsigned vectors    = 0;
    int unsigned miscompares = 0;

    logic [7:0] m0 [256];
    logic [7:0] m1 [256];
    logic [7:0] sb_q [$];

    always #5 clk = ~clk;

    data_memory #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .LATENCY(5)) dut (
        .CLK(clk), .RESET(rst0), .READ(rd0), .WRITE(wr0), .ADDRESS(a0),
        .WRITEDATA(d0), .READDATA(rdata0), .BUSYWAIT(busy0)
    );

    data_memory #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .LATENCY(1)) dut1 (
        .CLK(clk), .RESET(rst1), .READ(rd1), .WRITE(wr1), .ADDRESS(a1),
        .WRITEDATA(d1), .READDATA(rdata1), .BUSYWAIT(busy1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One CPU access; counts stall cycles and scores READDATA in the DONE cycle
    task automatic access(input int sel, input logic rd, input logic wr,
                          input logic [7:0] a, input logic [7:0] d,
                          input bit hold, input bit scramble);
        int unsigned lat;
        int unsigned n;
        bit          done;
        logic        b;
        logic [7:0]  exp;
        lat  = (sel == 0) ? 5 : 1;
        n    = 0;
        done = 1'b0;
        @(posedge clk); #1;
        if (sel == 0) begin rd0 = rd; wr0 = wr; a0 = a; d0 = d; end
        else          begin rd1 = rd; wr1 = wr; a1 = a; d1 = d; end
        if (rd) begin
            sb_q.push_back((sel == 0) ? m0[a] : m1[a]);
        end else if (wr) begin
            if (sel == 0) m0[a] = d; else m1[a] = d;
        end
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            b = (sel == 0) ? busy0 : busy1;
            if (b) begin
                n++;
                if (scramble && n == 2) begin
                    a0 = 8'(a + 1);
                    d0 = 8'hFF;
                end
            end else begin
                done = 1'b1;
            end
        end
        check(rd ? "busy_rd" : "busy_wr", n, lat + 1);
        if (rd) begin
            exp = sb_q.pop_front();
            check("rdata", (sel == 0) ? rdata0 : rdata1, exp);
        end
        if (!hold) begin
            if (sel == 0) begin rd0 = 1'b0; wr0 = 1'b0; end
            else          begin rd1 = 1'b0; wr1 = 1'b0; end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst0 = 1'b1; rd0 = 1'b1; wr0 = 1'b0; a0 = '0; d0 = '0;
        rst1 = 1'b1; rd1 = 1'b0; wr1 = 1'b0; a1 = '0; d1 = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("busy_in_reset", busy0, 1'b0);
        check("rdata_reset", rdata0, 8'h00);
        rd0 = 1'b0;
        @(posedge clk); #1;
        rst0 = 1'b0; rst1 = 1'b0;
        @(negedge clk);
        check("busy_idle", busy0, 1'b0);

        // Known contents for the locations the tests depend on
        access(0, 0, 1, 8'h03, 8'h00, 0, 0);
        access(0, 0, 1, 8'h11, 8'h42, 0, 0);
        access(0, 0, 1, 8'hFF, 8'h33, 0, 0);

        // Write then read back
        access(0, 0, 1, 8'h2A, 8'h5C, 0, 0);
        access(0, 1, 0, 8'h2A, 8'h00, 0, 0);

        // Inputs changed during ACCESS must be ignored
        access(0, 0, 1, 8'h10, 8'hAA, 0, 1);
        access(0, 1, 0, 8'h10, 8'h00, 0, 0);
        access(0, 1, 0, 8'h11, 8'h00, 0, 0);

        // Reset aborts a write at counter == 2
        @(posedge clk); #1;
        wr0 = 1'b1; a0 = 8'h03; d0 = 8'h77;
        @(posedge clk);
        @(posedge clk);
        @(posedge clk); #1;
        rst0 = 1'b1; wr0 = 1'b0;
        @(negedge clk);
        check("busy_rst_mid", busy0, 1'b0);
        @(posedge clk); #1;
        rst0 = 1'b0;
        @(negedge clk);
        check("busy_after_rst", busy0, 1'b0);
        check("rdata_after_rst", rdata0, 8'h00);
        access(0, 1, 0, 8'h03, 8'h00, 0, 0);
        access(0, 1, 0, 8'h2A, 8'h00, 0, 0);

        // Held READ: one idle-low cycle, then a second full-latency read
        access(0, 1, 0, 8'h10, 8'h00, 1, 0);
        access(0, 1, 0, 8'h10, 8'h00, 0, 0);

        // READ and WRITE together act as a read only
        access(0, 1, 1, 8'hFF, 8'h99, 0, 0);
        access(0, 1, 0, 8'hFF, 8'h00, 0, 0);

        // Short-latency instance
        access(1, 0, 1, 8'h00, 8'h01, 0, 0);
        access(1, 1, 0, 8'h00, 8'h00, 0, 0);
        access(1, 0, 1, 8'hFF, 8'hC3, 0, 0);
        access(1, 1, 0, 8'hFF, 8'h00, 0, 0);

        check("sb_empty", sb_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
